cp0_intr_ctrl: RTL and testbench
================================

Name: cp0_intr_ctrl

Overview:
- Parametrised coprocessor-0 interrupt/exception controller for the uMIPS_32 core.
- Holds the Status, Cause and EPC registers. Synchronises and latches N_IRQ external interrupt lines, with per-line masking and fixed priority.
- Supports nested exceptions through a Status/EPC shadow stack of depth NEST.
- Sits beside the control unit: the decoder supplies decoded exception and CP0 strobes; this block returns the PC redirect, CP0 read data and interrupt acknowledges.

Parameters:
- N_IRQ, 4, number of external interrupt lines (1..8).
- NEST, 2, Status/EPC stack depth, i.e. the maximum number of nested exceptions (1..8).
- EDGE, 1, 1 = rising-edge-latched IRQs, 0 = level IRQs with no latching.
- SYNC, 2, synchroniser flops on each irq line (0 = bypass).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  N_IRQ  asynchronous interrupt request lines.
- exc_sys  in  1  decoded syscall.
- exc_uni  in  1  unimplemented instruction.
- exc_ovr  in  1  arithmetic overflow (already qualified with add/sub/addi).
- i_mtc0  in  1  mtc0 strobe.
- i_mfc0  in  1  mfc0 strobe.
- i_eret  in  1  eret strobe.
- rd  in  5  CP0 register number: 12 = Status, 13 = Cause, 14 = EPC.
- wdata  in  32  mtc0 data.
- pc_cur  in  32  PC of the current instruction; saved for synchronous exceptions.
- pc_next  in  32  sequential or branch next PC; saved for interrupts.
- rdata  out  32  mfc0 read data.
- exc  out  1  exception or interrupt taken this cycle.
- selpc  out  2  00 normal, 01 eret (use epc_out), 10 exception vector.
- epc_out  out  32  top-of-stack EPC.
- inta  out  N_IRQ  one-hot acknowledge pulse.
- nest_full  out  1  stack depth == NEST.

Behaviour:
- **Reset (synchronous, rst=1 at an edge):**
  - status=0, cause=0, EPC stack=0, depth=0, pending=0, synchronisers=0.
  - All outputs read as 0 the cycle after reset: exc=0, selpc=00, inta=0, rdata=0, nest_full=0.
  - Reset mid-nest discards the whole stack.
- **Status layout:**
  - [0] IE (global interrupt enable), [1] SYS enable, [2] UNI enable, [3] OVR enable.
  - [8+N_IRQ-1:8] IM, per-line mask (1 = enabled).
  - All other bits read 0.
- **Cause layout:**
  - [3:2] ExcCode: 0 = int, 1 = sys, 2 = uni, 3 = ovr.
  - [8+N_IRQ-1:8] IP, live pending bits.
  - [31] NOVF, sticky; set when an exception is dropped because the stack is full.
  - [7:4] = index of the interrupt line taken (valid when ExcCode = 0).
  - Other bits 0.
- **IRQ path:**
  - irq passes through SYNC flops.
  - EDGE=1: pending[i] is set on a 0→1 transition of the synchronised line and cleared when inta[i] fires or by an mtc0 W1C to Cause.IP[i]. If set and clear occur in the same cycle, set wins.
  - EDGE=0: pending = synchronised line.
  - Latency from an irq rising edge to exc is SYNC+1 cycles, assuming enabled and no higher-priority event.
- **Take decision (combinational, same cycle):**
  - Candidates: ovr = exc_ovr&status[3]; uni = exc_uni&status[2]; sys = exc_sys&status[1]; int = status[0] & |(pending & IM).
  - Priority: ovr > uni > sys > int. Among interrupt lines, the lowest index wins.
  - exc = any candidate & ~nest_full.
  - inta is one-hot for the winning line only when int wins and is taken.
  - If nest_full and any candidate is present: exc=0, and NOVF is set at the edge.
- **On exc (at the edge):**
  - Push status[3:0] and EPC; depth += 1.
  - EPC top = pc_cur for synchronous exceptions, pc_next for interrupts.
  - status[3:0] ← 0; IM is unchanged.
  - Write ExcCode and the line index.
  - selpc = 10.
- **eret (i_eret & ~exc):**
  - selpc = 01; epc_out is valid in the same cycle.
  - At the edge: status[3:0] ← popped value; depth −= 1.
  - eret with depth == 0: selpc = 01, epc_out = 0, no state change.
- **mtc0 (i_mtc0 & ~exc):**
  - rd=12 writes IE/enables/IM.
  - rd=13 is W1C on IP (EDGE=1 only), plus writing bit 31 = 1 clears NOVF.
  - rd=14 overwrites the top EPC entry.
  - Other rd values are ignored.
  - If exc and mtc0 occur in the same cycle, the exception wins and the mtc0 is dropped.
- **mfc0:** rdata = the selected register (combinational, pre-edge value); 0 for any other rd or when i_mfc0=0.
- **Simultaneous eret and interrupt:** the interrupt is evaluated against the pre-eret status. Since status[0]=0 inside a handler, eret normally wins; the interrupt is taken on the next cycle if still pending.

Test Plan:
1. Reset, then mtc0 Status=0x0000_0F01 and pulse irq[2] (N_IRQ=4, SYNC=2, EDGE=1) → exc=1 and inta=4'b0100 exactly 3 cycles after the pulse; Cause=0x0000_0020; EPC=pc_next; Status[3:0]=0; pending[2] cleared.
2. Status enables=0xF with exc_ovr and exc_sys in the same cycle as pending irq[0] → ExcCode=3 (Cause[3:2]=11); inta=0; irq[0] stays pending and is taken after handler mtc0 Status[0]=1.
3. Nesting with NEST=2: take sys (pc_cur=0x100), re-enable, take uni (pc_cur=0x200); a third exception is dropped with Cause[31]=1 and nest_full=1. eret → epc_out=0x200; second eret → epc_out=0x100, Status restored to 0xF, depth 0.
4. EDGE=0, irq[1] held high with the line masked (IM[1]=0) → no exc. Unmask → exc next cycle. Deassert the line before IE is set → no exc.
5. mtc0 Cause with wdata=0x0000_0100 while pending[0]=1 in the same cycle as a new irq[0] edge → pending stays 1 (set wins). Without the new edge → cleared.
6. Assert rst during an active handler (depth=1, pending=0b1010) → next cycle all registers 0; eret then yields selpc=01 with epc_out=0.

Source files
------------

// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 interrupt/exception controller: Status/Cause/EPC, synchronised IRQ
// latching with mask and fixed priority, and a Status/EPC shadow stack for nesting.
module cp0_intr_ctrl #(
  parameter int unsigned N_IRQ = 4,
  parameter int unsigned NEST  = 2,
  parameter int unsigned EDGE  = 1,
  parameter int unsigned SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             exc_sys,
  input  logic             exc_uni,
  input  logic             exc_ovr,
  input  logic             i_mtc0,
  input  logic             i_mfc0,
  input  logic             i_eret,
  input  logic [4:0]       rd,
  input  logic [31:0]      wdata,
  input  logic [31:0]      pc_cur,
  input  logic [31:0]      pc_next,
  output logic [31:0]      rdata,
  output logic             exc,
  output logic [1:0]       selpc,
  output logic [31:0]      epc_out,
  output logic [N_IRQ-1:0] inta,
  output logic             nest_full
);

  localparam int unsigned DW = $clog2(NEST + 1);

  typedef enum logic [1:0] {
    EC_INT = 2'd0,
    EC_SYS = 2'd1,
    EC_UNI = 2'd2,
    EC_OVR = 2'd3
  } exc_code_t;

  logic [3:0]       r_st;
  logic [N_IRQ-1:0] r_im;
  exc_code_t        r_code;
  logic [2:0]       r_line;
  logic             r_novf;
  logic [31:0]      r_epc [NEST];
  logic [3:0]       r_stk [NEST];
  logic [DW-1:0]    r_depth;

  logic [N_IRQ-1:0] w_irq_s, w_pend, w_req, w_clr, w_inta, w_onehot;
  logic [31:0]      w_top_epc;
  logic [3:0]       w_top_st;
  logic             w_full, w_ovr, w_uni, w_sys, w_int, w_any, w_take;
  logic             w_ret, w_wr, w_hit;
  exc_code_t        w_code;
  logic [2:0]       w_line;

  if (SYNC > 0) begin : g_sync
    logic [N_IRQ-1:0] r_sync [SYNC];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < SYNC; k++) r_sync[k] <= '0;
      end else begin
        r_sync[0] <= irq;
        for (int unsigned k = 1; k < SYNC; k++) r_sync[k] <= r_sync[k-1];
      end
    end
    assign w_irq_s = r_sync[SYNC-1];
  end else begin : g_nosync
    assign w_irq_s = irq;
  end

  if (EDGE != 0) begin : g_edge
    logic [N_IRQ-1:0] r_prev, r_pend;
    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_prev <= '0;
        r_pend <= '0;
      end else begin
        r_prev <= w_irq_s;
        r_pend <= (r_pend & ~w_clr) | (w_irq_s & ~r_prev);
      end
    end
    assign w_pend = r_pend;
  end else begin : g_level
    assign w_pend = w_irq_s;
  end

  always_comb begin
    w_full = (r_depth == DW'(NEST));
    w_ovr  = exc_ovr & r_st[3];
    w_uni  = exc_uni & r_st[2];
    w_sys  = exc_sys & r_st[1];
    w_req  = w_pend & r_im;
    w_int  = r_st[0] & (|w_req);
    w_any  = w_ovr | w_uni | w_sys | w_int;
    w_take = w_any & ~w_full;

    w_hit    = 1'b0;
    w_line   = '0;
    w_onehot = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (w_req[i] && !w_hit) begin
        w_hit       = 1'b1;
        w_line      = 3'(i);
        w_onehot[i] = 1'b1;
      end
    end

    if (w_ovr)      w_code = EC_OVR;
    else if (w_uni) w_code = EC_UNI;
    else if (w_sys) w_code = EC_SYS;
    else            w_code = EC_INT;

    w_inta = (w_take && w_code == EC_INT) ? w_onehot : '0;
    w_ret  = i_eret & ~w_take;
    w_wr   = i_mtc0 & ~w_take;
    w_clr  = w_inta | ((w_wr && rd == 5'd13) ? wdata[8 +: N_IRQ] : '0);

    w_top_epc = '0;
    w_top_st  = '0;
    for (int unsigned k = 0; k < NEST; k++) begin
      if (r_depth == DW'(k + 1)) begin
        w_top_epc = r_epc[k];
        w_top_st  = r_stk[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (i_mfc0) begin
      case (rd)
        5'd12: begin
          rdata[3:0]        = r_st;
          rdata[8 +: N_IRQ] = r_im;
        end
        5'd13: begin
          rdata[31]         = r_novf;
          rdata[8 +: N_IRQ] = w_pend;
          rdata[7:4]        = {1'b0, r_line};
          rdata[3:2]        = r_code;
        end
        5'd14:   rdata = w_top_epc;
        default: rdata = '0;
      endcase
    end
  end

  assign exc       = w_take;
  assign selpc     = w_take ? 2'b10 : (i_eret ? 2'b01 : 2'b00);
  assign epc_out   = w_top_epc;
  assign inta      = w_inta;
  assign nest_full = w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= '0;
      r_im    <= '0;
      r_code  <= EC_INT;
      r_line  <= '0;
      r_novf  <= 1'b0;
      r_depth <= '0;
      for (int unsigned k = 0; k < NEST; k++) begin
        r_epc[k] <= '0;
        r_stk[k] <= '0;
      end
    end else begin
      if (w_take) begin
        for (int unsigned k = 0; k < NEST; k++) begin
          if (r_depth == DW'(k)) begin
            r_stk[k] <= r_st;
            r_epc[k] <= (w_code == EC_INT) ? pc_next : pc_cur;
          end
        end
        r_depth <= r_depth + DW'(1);
        r_st    <= '0;
        r_code  <= w_code;
        r_line  <= (w_code == EC_INT) ? w_line : '0;
      end else begin
        if (w_ret && r_depth != '0) begin
          r_st    <= w_top_st;
          r_depth <= r_depth - DW'(1);
        end
        if (w_wr) begin
          case (rd)
            5'd12: begin
              r_st <= wdata[3:0];
              r_im <= wdata[8 +: N_IRQ];
            end
            5'd13: if (wdata[31]) r_novf <= 1'b0;
            5'd14: begin
              for (int unsigned k = 0; k < NEST; k++)
                if (r_depth == DW'(k + 1)) r_epc[k] <= wdata;
            end
            default: ;
          endcase
        end
      end
      // Dropped-exception flag is set after any software clear so the set wins.
      if (w_any && w_full) r_novf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl: an edge-latched instance and a level instance
// share all inputs; expected values are hand-computed constants.
module tb_cp0_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        exc_sys, exc_uni, exc_ovr, i_mtc0, i_mfc0, i_eret;
  logic [4:0]  rd;
  logic [31:0] wdata, pc_cur, pc_next;

  logic [31:0] rdata_e, epc_e, rdata_l, epc_l;
  logic        exc_e, full_e, exc_l, full_l;
  logic [1:0]  selpc_e, selpc_l;
  logic [3:0]  inta_e, inta_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_intr_ctrl #(.N_IRQ(4), .NEST(2), .EDGE(1), .SYNC(2)) u_dut (
    .clk(clk), .rst(rst), .irq(irq), .exc_sys(exc_sys), .exc_uni(exc_uni),
    .exc_ovr(exc_ovr), .i_mtc0(i_mtc0), .i_mfc0(i_mfc0), .i_eret(i_eret),
    .rd(rd), .wdata(wdata), .pc_cur(pc_cur), .pc_next(pc_next),
    .rdata(rdata_e), .exc(exc_e), .selpc(selpc_e), .epc_out(epc_e),
    .inta(inta_e), .nest_full(full_e)
  );

  cp0_intr_ctrl #(.N_IRQ(4), .NEST(2), .EDGE(0), .SYNC(2)) u_dut_lvl (
    .clk(clk), .rst(rst), .irq(irq), .exc_sys(exc_sys), .exc_uni(exc_uni),
    .exc_ovr(exc_ovr), .i_mtc0(i_mtc0), .i_mfc0(i_mfc0), .i_eret(i_eret),
    .rd(rd), .wdata(wdata), .pc_cur(pc_cur), .pc_next(pc_next),
    .rdata(rdata_l), .exc(exc_l), .selpc(selpc_l), .epc_out(epc_l),
    .inta(inta_l), .nest_full(full_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic rdc(input string tag, input logic [4:0] r, input logic lvl,
                     input logic [31:0] expv);
    i_mfc0 = 1'b1;
    rd     = r;
    #1;
    chk(tag, lvl ? rdata_l : rdata_e, expv);
    i_mfc0 = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    i_mtc0 = 1'b1;
    rd     = r;
    wdata  = d;
    tick;
    i_mtc0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0;
    exc_sys = 1'b0; exc_uni = 1'b0; exc_ovr = 1'b0;
    i_mtc0 = 1'b0; i_mfc0 = 1'b0; i_eret = 1'b0;
    rd = '0; wdata = '0; pc_cur = '0; pc_next = '0;
    tick;
    rst = 1'b0;
    settle;
    chk("rst_exc", 32'(exc_e), 32'd0);
    chk("rst_selpc", 32'(selpc_e), 32'd0);
    chk("rst_inta", 32'(inta_e), 32'd0);
    chk("rst_full", 32'(full_e), 32'd0);
    rdc("rst_status", 5'd12, 1'b0, 32'h0);
    rdc("rst_cause", 5'd13, 1'b0, 32'h0);

    // irq[2] pulse taken exactly three edges later
    pc_next = 32'h1234; pc_cur = 32'hAAAA;
    mtc0(5'd12, 32'h0000_0F01);
    rdc("t1_status_wr", 5'd12, 1'b0, 32'h0000_0F01);
    irq = 4'b0100;
    settle; chk("t1_exc_c0", 32'(exc_e), 32'd0);
    tick; irq = '0;
    settle; chk("t1_exc_c1", 32'(exc_e), 32'd0);
    tick;
    settle; chk("t1_exc_c2", 32'(exc_e), 32'd0);
    tick;
    settle;
    chk("t1_exc_c3", 32'(exc_e), 32'd1);
    chk("t1_inta", 32'(inta_e), 32'h4);
    chk("t1_selpc", 32'(selpc_e), 32'd2);
    tick;
    rdc("t1_cause", 5'd13, 1'b0, 32'h0000_0020);
    rdc("t1_epc", 5'd14, 1'b0, 32'h0000_1234);
    rdc("t1_status", 5'd12, 1'b0, 32'h0000_0F00);
    i_eret = 1'b1;
    settle;
    chk("t1_eret_selpc", 32'(selpc_e), 32'd1);
    chk("t1_eret_epc", epc_e, 32'h1234);
    tick; i_eret = 1'b0;
    rdc("t1_status_pop", 5'd12, 1'b0, 32'h0000_0F01);

    // ovr beats sys and a pending interrupt; the interrupt is taken later
    mtc0(5'd12, 32'h0000_0F0E);
    irq = 4'b0001;
    tick; tick; tick;
    rdc("t2_cause_ip", 5'd13, 1'b0, 32'h0000_0120);
    mtc0(5'd12, 32'h0000_0F0F);
    exc_ovr = 1'b1; exc_sys = 1'b1; pc_cur = 32'h300;
    settle;
    chk("t2_exc", 32'(exc_e), 32'd1);
    chk("t2_inta", 32'(inta_e), 32'd0);
    tick;
    exc_ovr = 1'b0; exc_sys = 1'b0; irq = '0;
    rdc("t2_cause", 5'd13, 1'b0, 32'h0000_010C);
    rdc("t2_epc", 5'd14, 1'b0, 32'h0000_0300);
    chk("t2_exc_masked", 32'(exc_e), 32'd0);
    i_mtc0 = 1'b1; rd = 5'd12; wdata = 32'h0000_0F01; pc_next = 32'h404;
    settle;
    chk("t2_exc_mtc0cyc", 32'(exc_e), 32'd0);
    tick; i_mtc0 = 1'b0;
    settle;
    chk("t2_int_exc", 32'(exc_e), 32'd1);
    chk("t2_int_inta", 32'(inta_e), 32'h1);
    tick;
    rdc("t2_int_cause", 5'd13, 1'b0, 32'h0000_0000);
    rdc("t2_int_epc", 5'd14, 1'b0, 32'h0000_0404);
    chk("t2_full", 32'(full_e), 32'd1);
    i_eret = 1'b1;
    settle; chk("t2_eret1_epc", epc_e, 32'h404);
    tick;
    settle; chk("t2_eret2_epc", epc_e, 32'h300);
    tick; i_eret = 1'b0;
    rdc("t2_status_pop", 5'd12, 1'b0, 32'h0000_0F0F);

    // nesting to full, drop with NOVF, unwind
    exc_sys = 1'b1; pc_cur = 32'h100;
    settle; chk("t3_sys_exc", 32'(exc_e), 32'd1);
    tick; exc_sys = 1'b0;
    mtc0(5'd12, 32'h0000_0F0F);
    exc_uni = 1'b1; pc_cur = 32'h200;
    settle; chk("t3_uni_exc", 32'(exc_e), 32'd1);
    tick; exc_uni = 1'b0;
    settle; chk("t3_full", 32'(full_e), 32'd1);
    mtc0(5'd12, 32'h0000_0F0F);
    exc_ovr = 1'b1; pc_cur = 32'h300;
    settle;
    chk("t3_drop_exc", 32'(exc_e), 32'd0);
    chk("t3_drop_selpc", 32'(selpc_e), 32'd0);
    tick; exc_ovr = 1'b0;
    rdc("t3_novf", 5'd13, 1'b0, 32'h8000_0008);
    i_eret = 1'b1;
    settle;
    chk("t3_eret1_selpc", 32'(selpc_e), 32'd1);
    chk("t3_eret1_epc", epc_e, 32'h200);
    tick;
    settle; chk("t3_eret2_epc", epc_e, 32'h100);
    tick; i_eret = 1'b0;
    rdc("t3_status", 5'd12, 1'b0, 32'h0000_0F0F);
    chk("t3_not_full", 32'(full_e), 32'd0);
    rd = 5'd12;
    settle; chk("t3_rdata_nomfc0", rdata_e, 32'h0);
    i_eret = 1'b1;
    settle;
    chk("t3_eret0_selpc", 32'(selpc_e), 32'd1);
    chk("t3_eret0_epc", epc_e, 32'h0);
    tick; i_eret = 1'b0;
    rdc("t3_eret0_status", 5'd12, 1'b0, 32'h0000_0F0F);
    mtc0(5'd13, 32'h8000_0000);
    rdc("t3_novf_clr", 5'd13, 1'b0, 32'h0000_0008);

    // W1C of IP against a simultaneous new edge
    mtc0(5'd12, 32'h0000_0F0E);
    irq = 4'b0001; tick; irq = '0; tick; tick;
    rdc("t5_pend", 5'd13, 1'b0, 32'h0000_0108);
    irq = 4'b0001; tick; irq = '0; tick;
    mtc0(5'd13, 32'h0000_0100);
    rdc("t5_set_wins", 5'd13, 1'b0, 32'h0000_0108);
    mtc0(5'd13, 32'h0000_0100);
    rdc("t5_w1c", 5'd13, 1'b0, 32'h0000_0008);

    // reset inside a handler
    irq = 4'b1010; tick; irq = '0; tick; tick;
    exc_sys = 1'b1; pc_cur = 32'h500;
    settle; chk("t6_exc", 32'(exc_e), 32'd1);
    tick; exc_sys = 1'b0;
    rdc("t6_cause", 5'd13, 1'b0, 32'h0000_0A04);
    rst = 1'b1; tick; rst = 1'b0;
    settle;
    chk("t6_exc0", 32'(exc_e), 32'd0);
    chk("t6_full0", 32'(full_e), 32'd0);
    rdc("t6_status0", 5'd12, 1'b0, 32'h0);
    rdc("t6_cause0", 5'd13, 1'b0, 32'h0);
    rdc("t6_epc0", 5'd14, 1'b0, 32'h0);
    i_eret = 1'b1;
    settle;
    chk("t6_eret_selpc", 32'(selpc_e), 32'd1);
    chk("t6_eret_epc", epc_e, 32'h0);
    tick; i_eret = 1'b0;

    // level-sensitive instance: mask, unmask, deassert
    mtc0(5'd12, 32'h0000_0D01);
    irq = 4'b0010; tick; tick; tick;
    settle; chk("t4_masked", 32'(exc_l), 32'd0);
    rdc("t4_ip", 5'd13, 1'b1, 32'h0000_0200);
    mtc0(5'd12, 32'h0000_0F01);
    settle;
    chk("t4_unmask_exc", 32'(exc_l), 32'd1);
    chk("t4_unmask_inta", 32'(inta_l), 32'h2);
    tick;
    rdc("t4_cause", 5'd13, 1'b1, 32'h0000_0210);
    irq = '0; tick; tick;
    mtc0(5'd12, 32'h0000_0F01);
    settle; chk("t4_deassert", 32'(exc_l), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
